// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared tile codes, mover state/command types, map dimensions.
// Revision    : 1.0
// ============================================================================
package game_pkg;

    typedef enum logic [7:0] {
        BDR = 8'd0,
        SKY = 8'd1,
        BLK = 8'd2,
        GND = 8'd3,
        TKN = 8'd4
    } tile_e;

    typedef enum logic [2:0] {
        STATIONARY = 3'd0,
        MOVING_L   = 3'd1,
        MOVING_R   = 3'd2,
        SKID_L     = 3'd3,
        SKID_R     = 3'd4
    } mover_state_e;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_LEFT  = 2'd1,
        CMD_RIGHT = 2'd2
    } move_cmd_e;

    localparam int C_MAP_ROWS    = 12;
    localparam int C_MAP_COLS    = 17;
    localparam int C_BLOCK_WIDTH = 40;

    // Both buttons together cancel out.
    function automatic move_cmd_e decode_cmd(input logic left, input logic right);
        if (left && !right) begin
            return CMD_LEFT;
        end else if (right && !left) begin
            return CMD_RIGHT;
        end
        return CMD_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_probe.sv
`default_nettype none
// ============================================================================
// Module      : tile_probe
// Description : Probes the tile column at the leading edge of a horizontal step
//               and returns whether it is solid plus the flush clamp position.
// Revision    : 1.0
// ============================================================================
module tile_probe
    import game_pkg::*;
#(
    parameter int         CHARACTER_WIDTH  = 42,
    parameter int         CHARACTER_HEIGHT = 42,
    parameter int         BLOCK_WIDTH      = C_BLOCK_WIDTH,
    parameter int         MAP_ROWS         = C_MAP_ROWS,
    parameter int         MAP_COLS         = C_MAP_COLS,
    parameter logic [7:0] SOLID_TILE       = BLK
) (
    input  logic signed [31:0] x,
    input  logic signed [31:0] y,
    input  logic signed [31:0] step,
    input  logic               direction_left,
    input  logic [7:0]         map [MAP_ROWS][MAP_COLS],
    output logic               hit,
    output logic signed [31:0] clamp_x
);

    logic signed [31:0] w_probe_x;
    logic signed [31:0] w_bottom_y;
    logic signed [31:0] w_col;
    logic signed [31:0] w_row_top;
    logic signed [31:0] w_row_bot;
    logic               w_col_ok;
    logic               w_top_ok;
    logic               w_bot_ok;

    // Negative coordinates are off-map; checking sign first avoids the
    // truncating division folding -1..-39 onto column/row 0.
    always_comb begin
        w_probe_x  = direction_left ? (x - step) : (x + CHARACTER_WIDTH - 1 + step);
        w_bottom_y = y + CHARACTER_HEIGHT - 1;
        w_col      = w_probe_x / BLOCK_WIDTH;
        w_row_top  = y / BLOCK_WIDTH;
        w_row_bot  = w_bottom_y / BLOCK_WIDTH;
        w_col_ok   = (w_probe_x >= 0) && (w_col < MAP_COLS);
        w_top_ok   = (y >= 0) && (w_row_top < MAP_ROWS);
        w_bot_ok   = (w_bottom_y >= 0) && (w_row_bot < MAP_ROWS);
    end

    always_comb begin
        hit = 1'b0;
        for (int r = 0; r < MAP_ROWS; r++) begin
            for (int c = 0; c < MAP_COLS; c++) begin
                if (w_col_ok && (c == w_col) && (map[r][c] == SOLID_TILE) &&
                    ((w_top_ok && (r == w_row_top)) || (w_bot_ok && (r == w_row_bot)))) begin
                    hit = 1'b1;
                end
            end
        end
    end

    assign clamp_x = direction_left ? ((w_col + 1) * BLOCK_WIDTH)
                                    : ((w_col * BLOCK_WIDTH) - CHARACTER_WIDTH);

endmodule
`default_nettype wire

// File: rtl/character_horizontal_mover.sv
`default_nettype none
// ============================================================================
// Module      : character_horizontal_mover
// Description : Horizontal mover with acceleration, skid and tile/screen
//               clamping. Optional MOVER_RUN_EN adds a run input.
// Revision    : 1.0
// ============================================================================
module character_horizontal_mover
    import game_pkg::*;
#(
    parameter int         CHARACTER_WIDTH  = 42,
    parameter int         CHARACTER_HEIGHT = 42,
    parameter int         SCREEN_WIDTH     = 640,
    parameter int         BLOCK_WIDTH      = C_BLOCK_WIDTH,
    parameter int         MAP_ROWS         = C_MAP_ROWS,
    parameter int         MAP_COLS         = C_MAP_COLS,
    parameter int         START_X          = 100,
    parameter int         MAX_SPEED        = 4,
    parameter int         ACCEL_TICKS      = 8,
    parameter logic [7:0] SOLID_TILE       = BLK
) (
    input  logic               movement_clock,
    input  logic               reset,
    input  logic               left,
    input  logic               right,
`ifdef MOVER_RUN_EN
    input  logic               run,
`endif
    input  logic [7:0]         background [MAP_ROWS][MAP_COLS],
    input  logic signed [31:0] char_y,
    output logic signed [31:0] char_x,
    output logic signed [31:0] speed,
    output logic               facing_left,
    output logic               blocked
);

    mover_state_e       r_state, w_state_n;
    logic signed [31:0] r_x, w_x_n;
    logic signed [31:0] r_speed, w_speed_n;
    logic signed [31:0] r_cnt, w_cnt_n;
    logic               r_facing, w_facing_n;
    logic               r_blocked, w_blocked_n;

    move_cmd_e          w_cmd, w_own_cmd, w_opp_cmd;
    mover_state_e       w_opp_move, w_skid_state;
    logic               w_dir_left;
    logic               w_cnt_done;
    logic signed [31:0] w_ceiling;
    logic signed [31:0] w_probe_step;
    logic signed [31:0] w_new_x;
    logic               w_probe_hit;
    logic signed [31:0] w_probe_clamp_x;
    logic               w_clamp;
    logic signed [31:0] w_clamp_x;

`ifdef MOVER_RUN_EN
    localparam int C_RUN_CEILING = (2 * MAX_SPEED > BLOCK_WIDTH) ? BLOCK_WIDTH : 2 * MAX_SPEED;
    assign w_ceiling = run ? C_RUN_CEILING : MAX_SPEED;
`else
    assign w_ceiling = MAX_SPEED;
`endif

    assign w_cmd        = decode_cmd(left, right);
    assign w_dir_left   = (r_state == MOVING_L) || (r_state == SKID_L);
    assign w_own_cmd    = w_dir_left ? CMD_LEFT : CMD_RIGHT;
    assign w_opp_cmd    = w_dir_left ? CMD_RIGHT : CMD_LEFT;
    assign w_opp_move   = w_dir_left ? MOVING_R : MOVING_L;
    assign w_skid_state = w_dir_left ? SKID_L : SKID_R;
    assign w_cnt_done   = (r_cnt == ACCEL_TICKS - 1);
    assign w_new_x      = w_dir_left ? (r_x - r_speed) : (r_x + r_speed);
    // A standing character still looks one pixel ahead so a wall it touches reports blocked.
    assign w_probe_step = (r_speed == 0) ? 32'sd1 : r_speed;

    tile_probe #(
        .CHARACTER_WIDTH (CHARACTER_WIDTH),
        .CHARACTER_HEIGHT(CHARACTER_HEIGHT),
        .BLOCK_WIDTH     (BLOCK_WIDTH),
        .MAP_ROWS        (MAP_ROWS),
        .MAP_COLS        (MAP_COLS),
        .SOLID_TILE      (SOLID_TILE)
    ) u_tile_probe (
        .x             (r_x),
        .y             (char_y),
        .step          (w_probe_step),
        .direction_left(w_dir_left),
        .map           (background),
        .hit           (w_probe_hit),
        .clamp_x       (w_probe_clamp_x)
    );

    always_comb begin
        w_clamp   = 1'b0;
        w_clamp_x = w_new_x;
        if (w_probe_hit) begin
            w_clamp   = 1'b1;
            w_clamp_x = w_probe_clamp_x;
        end else if (w_new_x < 0) begin
            w_clamp   = 1'b1;
            w_clamp_x = '0;
        end else if (w_new_x + CHARACTER_WIDTH > SCREEN_WIDTH) begin
            w_clamp   = 1'b1;
            w_clamp_x = SCREEN_WIDTH - CHARACTER_WIDTH;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_x_n       = r_x;
        w_speed_n   = r_speed;
        w_cnt_n     = r_cnt;
        w_facing_n  = r_facing;
        w_blocked_n = 1'b0;
        case (r_state)
            STATIONARY: begin
                if (w_cmd == CMD_LEFT) begin
                    w_state_n  = MOVING_L;
                    w_facing_n = 1'b1;
                    w_speed_n  = '0;
                    w_cnt_n    = '0;
                end else if (w_cmd == CMD_RIGHT) begin
                    w_state_n  = MOVING_R;
                    w_facing_n = 1'b0;
                    w_speed_n  = '0;
                    w_cnt_n    = '0;
                end
            end
            MOVING_L, MOVING_R: begin
                if (w_cmd == w_own_cmd) begin
                    if (w_cnt_done) begin
                        w_cnt_n = '0;
                        if (r_speed < w_ceiling) begin
                            w_speed_n = r_speed + 1;
                        end else if (r_speed > w_ceiling) begin
                            w_speed_n = r_speed - 1;
                        end
                    end else begin
                        w_cnt_n = r_cnt + 1;
                    end
                end else if (w_cmd == w_opp_cmd) begin
                    w_cnt_n = '0;
                    if (r_speed == 0) begin
                        w_state_n  = w_opp_move;
                        w_facing_n = !w_dir_left;
                    end else begin
                        w_state_n = w_skid_state;
                    end
                end else if (r_speed == 0) begin
                    w_state_n = STATIONARY;
                    w_cnt_n   = '0;
                end else if (w_cnt_done) begin
                    w_cnt_n   = '0;
                    w_speed_n = r_speed - 1;
                    if (r_speed == 1) begin
                        w_state_n = STATIONARY;
                    end
                end else begin
                    w_cnt_n = r_cnt + 1;
                end
            end
            SKID_L, SKID_R: begin
                w_cnt_n = '0;
                if (r_speed <= 1) begin
                    w_speed_n = '0;
                    if (w_cmd == w_opp_cmd) begin
                        w_state_n  = w_opp_move;
                        w_facing_n = !w_dir_left;
                    end else begin
                        w_state_n = STATIONARY;
                    end
                end else begin
                    w_speed_n = r_speed - 1;
                end
            end
            default: w_state_n = STATIONARY;
        endcase

        // A clamp overrides whatever the speed/state logic decided this tick.
        if (r_state != STATIONARY) begin
            if (w_clamp) begin
                w_x_n       = w_clamp_x;
                w_speed_n   = '0;
                w_cnt_n     = '0;
                w_state_n   = STATIONARY;
                w_facing_n  = r_facing;
                w_blocked_n = 1'b1;
            end else begin
                w_x_n = w_new_x;
            end
        end
    end

    always_ff @(posedge movement_clock) begin
        if (reset) begin
            r_state   <= STATIONARY;
            r_x       <= START_X;
            r_speed   <= '0;
            r_cnt     <= '0;
            r_facing  <= 1'b0;
            r_blocked <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_x       <= w_x_n;
            r_speed   <= w_speed_n;
            r_cnt     <= w_cnt_n;
            r_facing  <= w_facing_n;
            r_blocked <= w_blocked_n;
        end
    end

    assign char_x      = r_x;
    assign speed       = r_speed;
    assign facing_left = r_facing;
    assign blocked     = r_blocked;

endmodule
`default_nettype wire
